// File: rtl/tdm_demux.sv
// tdm_demux: receive end of an N:1 TDM mux line; rebuilds the parallel word per SYNC-marked frame.
// Define TDM_DEMUX_PARITY_EN to append an even-parity slot (N+1 slots per frame).
module tdm_demux #(
    parameter int N = 4,
`ifdef TDM_DEMUX_PARITY_EN
    localparam int SW = $clog2(N + 1)
`else
    localparam int SW = $clog2(N)
`endif
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          EN,
    input  logic          SYNC,
    input  logic          X,
    output logic [N-1:0]  Q,
    output logic [SW-1:0] S,
    output logic          VALID,
    output logic          LOCKED,
    output logic          ERR
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOTS = N + 1;
`else
    localparam int SLOTS = N;
`endif
    // The last slot is consumed straight from X, so the shift register holds one bit fewer.
    localparam int SRW = SLOTS - 1;
    localparam logic [SW-1:0] LAST = SW'(SLOTS - 1);

    typedef enum logic {HUNT, RUN} state_t;

    state_t          state_q;
    logic [SRW-1:0]  sr_q;
    logic [N-1:0]    q_q;
    logic [SW-1:0]   s_q;
    logic            valid_q;
    logic            locked_q;
    logic            err_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= HUNT;
            sr_q     <= '0;
            q_q      <= '0;
            s_q      <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (EN) begin
                case (state_q)
                    HUNT: begin
                        if (SYNC) begin
                            sr_q[0]  <= X;
                            s_q      <= SW'(1);
                            state_q  <= RUN;
                            locked_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        // Early SYNC outranks frame completion, including on the last slot.
                        if (SYNC) begin
                            if (s_q != '0) err_q <= 1'b1;
                            sr_q[0] <= X;
                            s_q     <= SW'(1);
                        end else if (s_q == '0) begin
                            err_q    <= 1'b1;
                            state_q  <= HUNT;
                            locked_q <= 1'b0;
                        end else if (s_q == LAST) begin
`ifdef TDM_DEMUX_PARITY_EN
                            if ((^{X, sr_q}) == 1'b0) begin
                                q_q     <= sr_q;
                                valid_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
`else
                            q_q     <= {X, sr_q};
                            valid_q <= 1'b1;
`endif
                            s_q <= '0;
                        end else begin
                            sr_q[s_q] <= X;
                            s_q       <= s_q + SW'(1);
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign Q      = q_q;
    assign S      = s_q;
    assign VALID  = valid_q;
    assign LOCKED = locked_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed frames plus randomized TDM traffic checked against a frame-queue model.
module tb_tdm_demux;

    localparam int N = 4;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOTS = N + 1;
    localparam int SW = $clog2(N + 1);
`else
    localparam int SLOTS = N;
    localparam int SW = $clog2(N);
`endif
    localparam int LS = SLOTS - 1;

    logic          CLK = 1'b0;
    logic          RESET, EN, SYNC, X;
    logic [N-1:0]  Q;
    logic [SW-1:0] S;
    logic          VALID, LOCKED, ERR;

    int n_vec = 0;
    int n_err = 0;

    tdm_demux #(.N(N)) dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .SYNC(SYNC), .X(X),
        .Q(Q), .S(S), .VALID(VALID), .LOCKED(LOCKED), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Reference: the bits gathered since the last accepted SYNC; empty means "expecting slot 0".
    bit           m_frame[$];
    bit           m_locked;
    logic [N-1:0] m_q;
    bit           m_valid, m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_frame.delete();
        m_locked = 1'b0;
        m_q      = '0;
        m_valid  = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic model_sample(input bit en, input bit sync, input bit x);
        bit par;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (en) begin
            if (sync) begin
                if (m_locked && m_frame.size() != 0) m_err = 1'b1;
                m_frame.delete();
                m_frame.push_back(x);
                m_locked = 1'b1;
            end else if (m_locked) begin
                if (m_frame.size() == 0) begin
                    m_err    = 1'b1;
                    m_locked = 1'b0;
                end else begin
                    m_frame.push_back(x);
                    if (m_frame.size() == SLOTS) begin
                        par = 1'b0;
                        foreach (m_frame[i]) par ^= m_frame[i];
`ifndef TDM_DEMUX_PARITY_EN
                        par = 1'b0;
`endif
                        if (!par) begin
                            for (int i = 0; i < N; i++) m_q[i] = m_frame[i];
                            m_valid = 1'b1;
                        end else begin
                            m_err = 1'b1;
                        end
                        m_frame.delete();
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("q", 32'(Q), 32'(m_q));
        check("s", 32'(S), 32'(m_frame.size()));
        check("valid", 32'(VALID), 32'(m_valid));
        check("locked", 32'(LOCKED), 32'(m_locked));
        check("err", 32'(ERR), 32'(m_err));
    endtask

    task automatic step(input bit en, input bit sync, input bit x);
        EN = en; SYNC = sync; X = x;
        @(posedge CLK);
        model_sample(en, sync, x);
        #1;
        check_outputs();
    endtask

    task automatic async_reset();
        #2 RESET = 1'b1;
        #1;
        check("rst_q", 32'(Q), 32'h0);
        check("rst_s", 32'(S), 32'h0);
        check("rst_valid", 32'(VALID), 32'h0);
        check("rst_locked", 32'(LOCKED), 32'h0);
        check("rst_err", 32'(ERR), 32'h0);
        model_reset();
        #1 RESET = 1'b0;
    endtask

    function automatic bit tx_bit(input logic [N-1:0] w, input int pos, input bit bad_par);
        if (pos < N) return w[pos];
        return (^w) ^ bad_par;
    endfunction

    task automatic send_slots(input logic [N-1:0] w, input int first, input int last,
                              input bit gap, input bit bad_par);
        for (int p = first; p <= last; p++) begin
            step(1'b1, p == 0, tx_bit(w, p, bad_par));
            if (gap) step(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [N-1:0] tx_word;
        int           tx_pos;
        bit           en, sync, bad_par;

        RESET = 1'b1; EN = 1'b0; SYNC = 1'b0; X = 1'b0;
        model_reset();
        #3;
        check_outputs();
        #3 RESET = 1'b0;

        // Basic frame
        step(1'b1, 1'b1, 1'b1);
        check("lock_first", 32'(LOCKED), 32'h1);
        send_slots(4'b1011, 1, LS, 1'b0, 1'b0);
        check("basic_q", 32'(Q), 32'hB);
        check("basic_valid", 32'(VALID), 32'h1);
        step(1'b0, 1'b0, 1'b0);

        // Gapped back-to-back frames
        send_slots(4'b1011, 0, LS, 1'b1, 1'b0);
        send_slots(4'b0110, 0, LS - 1, 1'b1, 1'b0);
        send_slots(4'b0110, LS, LS, 1'b0, 1'b0);
        check("gap_q", 32'(Q), 32'h6);

        // Missing SYNC, then recovery
        send_slots(4'b1011, 0, LS, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("lost_err", 32'(ERR), 32'h1);
        check("lost_locked", 32'(LOCKED), 32'h0);
        check("lost_q", 32'(Q), 32'hB);
        send_slots(4'b0001, 0, LS, 1'b0, 1'b0);
        check("recover_q", 32'(Q), 32'h1);

        // Early SYNC at slot 2
        send_slots(4'b1111, 0, 1, 1'b0, 1'b0);
        send_slots(4'b0100, 0, 0, 1'b0, 1'b0);
        check("early_err", 32'(ERR), 32'h1);
        check("early_s", 32'(S), 32'h1);
        check("early_locked", 32'(LOCKED), 32'h1);
        send_slots(4'b0100, 1, LS, 1'b0, 1'b0);
        check("early_q", 32'(Q), 32'h4);
        check("early_valid", 32'(VALID), 32'h1);

`ifdef TDM_DEMUX_PARITY_EN
        send_slots(4'b1011, 0, LS, 1'b0, 1'b0);
        check("par_ok_q", 32'(Q), 32'hB);
        send_slots(4'b1011, 0, LS, 1'b0, 1'b1);
        check("par_bad_err", 32'(ERR), 32'h1);
        check("par_bad_valid", 32'(VALID), 32'h0);
`endif

        // Mid-frame asynchronous reset discards the partial frame
        send_slots(4'b1101, 0, 1, 1'b0, 1'b0);
        async_reset();

        // Randomized traffic with occasional faults
        tx_pos  = 0;
        tx_word = N'($urandom);
        bad_par = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            en = ($urandom_range(0, 3) != 0);
            if (en) begin
                sync = (tx_pos == 0);
                if ($urandom_range(0, 99) < 4) sync = ~sync;
                step(1'b1, sync, tx_bit(tx_word, tx_pos, bad_par));
                tx_pos++;
                if (tx_pos == SLOTS) begin
                    tx_pos  = 0;
                    tx_word = N'($urandom);
                    bad_par = ($urandom_range(0, 9) == 0);
                end
            end else begin
                step(1'b0, 1'($urandom), 1'($urandom));
            end
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
